// File: rtl/mtrap_pkg.sv
// Shared constants and types for the machine-mode trap unit: CSR addresses,
// interrupt cause codes, mstatus bit positions and the handshake FSM states.
package mtrap_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    localparam logic [4:0] CAUSE_MSI       = 5'd3;
    localparam logic [4:0] CAUSE_MTI       = 5'd7;
    localparam logic [4:0] CAUSE_MEI       = 5'd11;
    localparam logic [4:0] CAUSE_PLAT_BASE = 5'd16;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LO   = 11;
    localparam int MSTATUS_MPP_HI   = 12;

    localparam logic [1:0] MODE_U = 2'b00;
    localparam logic [1:0] MODE_M = 2'b11;

    // MXL=1 (RV32), extensions I and M
    localparam logic [31:0] MISA_VALUE = 32'h4000_1100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_COOL  = 2'd3
    } irqState_t;

    // Writable mie bits: MSIE, MTIE, MEIE plus one bit per platform line
    function automatic logic [31:0] mieWritableMask(input int nplat);
        logic [31:0] m;
        m = 32'h0000_0888;
        for (int i = 0; i < nplat; i++) begin
            m[16+i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/mtrap_irq_arb.sv
// Interrupt arbitration: registers the enabled sources, picks the highest
// priority cause and runs the level/reply handshake towards the core.
module mtrap_irq_arb
    import mtrap_pkg::*;
#(
    parameter int NPLAT = 4,
    localparam int PLAT_W = (NPLAT > 0) ? NPLAT : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_mie,
    input  logic              i_meiEn,
    input  logic              i_msiEn,
    input  logic              i_mtiEn,
    input  logic [PLAT_W-1:0] i_platEn,
    input  logic              i_reply,
    output logic              o_interrupt,
    output logic [4:0]        o_intCode
);

    logic              r_pendQ;
    logic              r_meiQ;
    logic              r_msiQ;
    logic              r_mtiQ;
    logic [PLAT_W-1:0] r_platQ;
    logic              r_replyQ;
    irqState_t         r_state;
    logic [4:0]        w_winCode;

    // Register the global pending flag together with the per-source view it came from
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pendQ  <= 1'b0;
            r_meiQ   <= 1'b0;
            r_msiQ   <= 1'b0;
            r_mtiQ   <= 1'b0;
            r_platQ  <= '0;
            r_replyQ <= 1'b0;
        end else begin
            r_pendQ  <= i_mie & (i_meiEn | i_msiEn | i_mtiEn | (|i_platEn));
            r_meiQ   <= i_meiEn;
            r_msiQ   <= i_msiEn;
            r_mtiQ   <= i_mtiEn;
            r_platQ  <= i_platEn;
            r_replyQ <= i_reply;
        end
    end

    // Fixed priority: MEI > MSI > MTI > platform lines, lowest index first
    always_comb begin
        w_winCode = 5'd0;
        for (int i = NPLAT - 1; i >= 0; i--) begin
            if (r_platQ[i]) begin
                w_winCode = CAUSE_PLAT_BASE + 5'(i);
            end
        end
        if (r_mtiQ) begin
            w_winCode = CAUSE_MTI;
        end
        if (r_msiQ) begin
            w_winCode = CAUSE_MSI;
        end
        if (r_meiQ) begin
            w_winCode = CAUSE_MEI;
        end
    end

    // Handshake: latch the cause, raise the request, hold until reply, then one cool-down cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            o_interrupt <= 1'b0;
            o_intCode   <= 5'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_pendQ) begin
                        o_intCode <= w_winCode;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    o_interrupt <= 1'b1;
                    r_state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_replyQ) begin
                        o_interrupt <= 1'b0;
                        r_state     <= ST_COOL;
                    end
                end
                ST_COOL: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/mtrap_unit.sv
// Machine-mode CSR file and trap controller sitting beside the core:
// CSR read/write port, trap entry/mret state updates, mcycle and interrupts.
module mtrap_unit
    import mtrap_pkg::*;
#(
    parameter int          NPLAT       = 4,
    parameter logic [31:0] RESET_VEC   = 32'h0,
    parameter logic [31:0] HARTID      = 32'h0,
    parameter bit          VECTORED_EN = 1'b1,
    localparam int         PLAT_W      = (NPLAT > 0) ? NPLAT : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       csr_a,
    input  logic [31:0]       csr_d,
    input  logic              csr_we,
    output logic [31:0]       csr_spo,
    input  logic              msip,
    input  logic              mtip,
    input  logic              meip,
    input  logic [PLAT_W-1:0] plat_ip,
    input  logic              exc_enter,
    input  logic              exc_isint,
    input  logic [31:0]       exc_pc,
    input  logic [3:0]        exc_code,
    input  logic [31:0]       exc_tval,
    input  logic              exc_leave,
    output logic [31:0]       trap_vec,
    output logic [31:0]       mepc_out,
    output logic              interrupt,
    output logic [4:0]        int_code,
    input  logic              int_reply
);

    localparam logic [31:0] MIE_MASK   = mieWritableMask(NPLAT);
    localparam logic [31:0] MTVEC_INIT = {RESET_VEC[31:2], 1'b0, VECTORED_EN ? RESET_VEC[0] : 1'b0};

    logic              r_mstatusMie;
    logic              r_mstatusMpie;
    logic [1:0]        r_mstatusMpp;
    logic [1:0]        r_mode;
    logic [31:0]       r_mieCsr;
    logic [31:0]       r_mtvec;
    logic [31:0]       r_mscratch;
    logic [31:0]       r_mepc;
    logic [31:0]       r_mcause;
    logic [31:0]       r_mtval;
    logic [63:0]       r_mcycle;
    logic [31:0]       r_mepcOut;

    logic              w_csrWr;
    logic [1:0]        w_mppWr;
    logic [31:0]       w_mstatus;
    logic [31:0]       w_mip;
    logic [31:0]       w_rdata;
    logic [PLAT_W-1:0] w_platEn;
    logic [4:0]        w_intCode;
    logic              w_vectored;

    // Trap entry and mret take the cycle; a software write in the same cycle is dropped
    assign w_csrWr   = csr_we & ~exc_enter & ~exc_leave;
    assign w_mppWr   = (csr_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] == MODE_M) ? MODE_M : MODE_U;
    assign w_mstatus = {19'b0, r_mstatusMpp, 3'b0, r_mstatusMpie, 3'b0, r_mstatusMie, 3'b0};

    // Live pending view and the per-line enabled platform sources
    always_comb begin
        w_mip    = 32'h0;
        w_platEn = '0;
        w_mip[3]  = msip;
        w_mip[7]  = mtip;
        w_mip[11] = meip;
        for (int i = 0; i < NPLAT; i++) begin
            w_mip[16+i] = plat_ip[i];
            w_platEn[i] = plat_ip[i] & r_mieCsr[16+i];
        end
    end

    // mstatus fields and the current privilege mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mstatusMie  <= 1'b0;
            r_mstatusMpie <= 1'b1;
            r_mstatusMpp  <= MODE_M;
            r_mode        <= MODE_M;
        end else if (exc_enter) begin
            r_mstatusMpie <= r_mstatusMie;
            r_mstatusMie  <= 1'b0;
            r_mstatusMpp  <= r_mode;
            r_mode        <= MODE_M;
        end else if (exc_leave) begin
            r_mstatusMie  <= r_mstatusMpie;
            r_mstatusMpie <= 1'b1;
            r_mode        <= r_mstatusMpp;
            r_mstatusMpp  <= MODE_U;
        end else if (w_csrWr && csr_a == CSR_MSTATUS) begin
            r_mstatusMie  <= csr_d[MSTATUS_MIE_BIT];
            r_mstatusMpie <= csr_d[MSTATUS_MPIE_BIT];
            r_mstatusMpp  <= w_mppWr;
        end
    end

    // Plain read/write CSRs, with trap entry overriding mepc, mcause and mtval
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mieCsr   <= 32'h0;
            r_mtvec    <= MTVEC_INIT;
            r_mscratch <= 32'h0;
            r_mepc     <= 32'h0;
            r_mcause   <= 32'h0;
            r_mtval    <= 32'h0;
        end else if (exc_enter) begin
            r_mepc   <= exc_pc;
            r_mtval  <= exc_tval;
            r_mcause <= exc_isint ? {1'b1, 26'b0, w_intCode} : {28'b0, exc_code};
        end else if (w_csrWr) begin
            case (csr_a)
                CSR_MIE:      r_mieCsr   <= csr_d & MIE_MASK;
                CSR_MTVEC:    r_mtvec    <= {csr_d[31:2], 1'b0, VECTORED_EN ? csr_d[0] : 1'b0};
                CSR_MSCRATCH: r_mscratch <= csr_d;
                CSR_MEPC:     r_mepc     <= csr_d;
                CSR_MCAUSE:   r_mcause   <= csr_d;
                CSR_MTVAL:    r_mtval    <= csr_d;
                default:      ;
            endcase
        end
    end

    // Free-running cycle counter; a software write replaces one half and freezes the other
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcycle <= 64'h0;
        end else if (w_csrWr && csr_a == CSR_MCYCLE) begin
            r_mcycle[31:0] <= csr_d;
        end else if (w_csrWr && csr_a == CSR_MCYCLEH) begin
            r_mcycle[63:32] <= csr_d;
        end else begin
            r_mcycle <= r_mcycle + 64'd1;
        end
    end

    // Registered copy of mepc for the core's return path
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mepcOut <= 32'h0;
        end else begin
            r_mepcOut <= {r_mepc[31:2], 2'b00};
        end
    end

    // Combinational CSR read mux
    always_comb begin
        w_rdata = 32'h0;
        case (csr_a)
            CSR_MSTATUS:  w_rdata = w_mstatus;
            CSR_MISA:     w_rdata = MISA_VALUE;
            CSR_MIE:      w_rdata = r_mieCsr;
            CSR_MTVEC:    w_rdata = r_mtvec;
            CSR_MSCRATCH: w_rdata = r_mscratch;
            CSR_MEPC:     w_rdata = {r_mepc[31:2], 2'b00};
            CSR_MCAUSE:   w_rdata = r_mcause;
            CSR_MTVAL:    w_rdata = r_mtval;
            CSR_MIP:      w_rdata = w_mip;
            CSR_MCYCLE:   w_rdata = r_mcycle[31:0];
            CSR_MCYCLEH:  w_rdata = r_mcycle[63:32];
            CSR_CYCLE:    w_rdata = r_mcycle[31:0];
            CSR_CYCLEH:   w_rdata = r_mcycle[63:32];
            CSR_MHARTID:  w_rdata = HARTID;
            default:      w_rdata = 32'h0;
        endcase
    end

    assign w_vectored = r_mtvec[0] & VECTORED_EN & exc_isint;
    assign trap_vec   = {r_mtvec[31:2], 2'b00} + (w_vectored ? {25'b0, w_intCode, 2'b00} : 32'h0);
    assign csr_spo    = w_rdata;
    assign mepc_out   = r_mepcOut;
    assign int_code   = w_intCode;

    mtrap_irq_arb #(
        .NPLAT(NPLAT)
    ) u_irqArb (
        .clk        (clk),
        .rst        (rst),
        .i_mie      (r_mstatusMie),
        .i_meiEn    (meip & r_mieCsr[11]),
        .i_msiEn    (msip & r_mieCsr[3]),
        .i_mtiEn    (mtip & r_mieCsr[7]),
        .i_platEn   (w_platEn),
        .i_reply    (int_reply),
        .o_interrupt(interrupt),
        .o_intCode  (w_intCode)
    );

endmodule
